nonce_tx_framer: RTL and testbench
==================================

// Module: nonce_tx_framer
// PURPOSE
//  Downstream of the miner core, upstream of the UART transmitter. Queues found nonces and
//  serialises each one into a 6-byte frame: SYNC, nonce LE bytes 0..3, XOR checksum.
//  Bytes are handed to the UART one at a time via its transmit/tx_byte/is_transmitting
//  handshake. The host resynchronises on SYNC.
// PARAMETERS
//  SYNC_BYTE   8'hAA  first byte of every frame
//  FIFO_DEPTH  4      nonce queue entries (power of 2, >=2)
//  OVF_W       8      overflow counter width
// PORTS
//  clk          in   1   master clock (UART clock domain)
//  rst_n        in   1   asynchronous active-low reset
//  nonce_valid  in   1   push nonce this cycle
//  nonce        in   32  nonce value, sampled when nonce_valid=1
//  nonce_ready  out  1   1 = queue not full
//  tx_busy      in   1   UART is_transmitting
//  tx_transmit  out  1   one-cycle request to UART to send tx_byte
//  tx_byte      out  8   byte to send, valid while tx_transmit=1
//  busy         out  1   1 = frame in progress or queue non-empty
//  ovf_count    out  OVF_W  nonces dropped on full queue, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty; FSM=IDLE; tx_transmit=0; tx_byte=0; ovf_count=0;
//   nonce_ready=1; busy=0. All outputs are registered.
//  Queue: a push when not full is stored. A push when full is dropped and ovf_count+1,
//   saturating at all-ones. A push and an FSM pop in the same cycle when full: the pop
//   frees the slot first, so the push is accepted.
//  FSM states:
//   IDLE: if FIFO non-empty -> LOAD.
//   LOAD: pop the head into the 32b shift reg; csum = n[7:0]^n[15:8]^n[23:16]^n[31:24];
//         byte_idx=0 -> SEND.
//   SEND: when tx_busy=0, drive tx_transmit=1 for exactly 1 cycle with tx_byte =
//         idx0 SYNC_BYTE, idx1..4 nonce bytes LSB first, idx5 csum -> ACK.
//   ACK:  wait for tx_busy=1 (the UART registers its state 1 cycle after the request) -> DONE.
//         If tx_busy is not seen within 4 cycles, return to SEND and re-issue the same byte.
//   DONE: wait for tx_busy=0. Then, if byte_idx==5 -> IDLE, else byte_idx+1 -> SEND.
//  tx_transmit is never high while tx_busy=1 and is never high for 2 consecutive cycles.
//  Latency: a nonce pushed into an empty queue with the UART idle gives tx_transmit
//   3 cycles later (push, IDLE, LOAD, SEND).
//  Frames go out whole and in FIFO order; no interleaving.
//  Throughput bound: 1 frame per 6 UART byte times. Extra nonces queue up, then drop.
//  busy = (state!=IDLE) | !empty.
//  Reset mid-frame: the partial frame is abandoned and the queue is flushed. Because SEND
//   waits for tx_busy=0, a byte the UART is still shifting finishes before the next frame;
//   the host recovers on SYNC.
//  FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguished by
//   the MSB on wrap.
// STRUCTURE
//  Shared package: SYNC_BYTE, FRAME_LEN=6, ACK_TIMEOUT=4, FSM state encodings
//   (IDLE/LOAD/SEND/ACK/DONE). The host-side tool uses the same constants.
//  One sub-module: sync_fifo (params WIDTH=32, DEPTH), with ports push, pop, din, dout,
//   full, empty. It is reusable for the RX work-blob path.
//  The top level holds the FSM, the byte mux, the checksum and the overflow counter.
// TESTING
//  Bench uses the real uart model loopback plus a byte monitor on the tx line.
//  1 Push 32'h12345678, UART idle -> tx bytes AA 78 56 34 12 08; busy falls after the last
//    stop bit.
//  2 Push 3 nonces back-to-back (01020304, 0, FFFFFFFF) -> 3 ordered frames; csums 04, 00, 00.
//  3 Push 6 nonces in 6 cycles with FIFO_DEPTH=4 -> 5 frames (1 popped early), ovf_count=1,
//    nonce_ready=0 while full.
//  4 Full queue, push in the same cycle as the LOAD pop -> accepted, ovf_count unchanged.
//  5 rst_n low during byte idx 2 -> tx_transmit=0 immediately, queue empty; the next push
//    after release gives a full frame starting with AA, sent only after tx_busy falls.
//  6 Stub holds tx_busy=0 after a request -> re-request of the same byte after 4 cycles;
//    assert tx_transmit never high 2 consecutive cycles or while tx_busy=1.

Source files
------------

// File: rtl/nonce_tx_framer_pkg.sv
// Shared constants for the nonce TX framer and the host-side frame parser.
// Latency: n/a (constants, types and one pure function).
// Backpressure: n/a.
package nonce_tx_framer_pkg;

  // Frame layout: SYNC, nonce byte 0..3 (LSB first), XOR checksum.
  localparam logic [7:0] SYNC_BYTE   = 8'hAA;
  localparam int         FRAME_LEN   = 6;
  localparam int         ACK_TIMEOUT = 4;

  localparam int                  IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam int                  ACK_W    = $clog2(ACK_TIMEOUT);
  localparam logic [ACK_W-1:0]    ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Checksum byte appended after the nonce: XOR of its four bytes.
  function automatic logic [7:0] nonce_csum(input logic [31:0] n);
    return n[7:0] ^ n[15:8] ^ n[23:16] ^ n[31:24];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read (dout shows the oldest entry).
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports: clk, rst_n (async, active low); push/din write; pop advances the head;
//        dout = head entry; full/empty status decoded from the pointers.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/nonce_tx_framer.sv
// Queues found nonces and sends each as a 6-byte frame (SYNC, LE nonce, XOR) to the UART.
// Latency: push into empty queue with UART idle -> tx_transmit 3 cycles after the push edge.
// Backpressure: nonce_ready=0 when the queue is full; pushes then are dropped and counted.
//
// Ports: clk, rst_n (async, active low); nonce_valid/nonce/nonce_ready from the miner;
//        tx_busy/tx_transmit/tx_byte to the UART; busy and ovf_count as status.
module nonce_tx_framer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hAA,
  parameter int         FIFO_DEPTH = 4,
  parameter int         OVF_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nonce_valid,
  input  logic [31:0]      nonce,
  output logic             nonce_ready,
  input  logic             tx_busy,
  output logic             tx_transmit,
  output logic [7:0]       tx_byte,
  output logic             busy,
  output logic [OVF_W-1:0] ovf_count
);

  import nonce_tx_framer_pkg::*;

  state_t           state;
  logic [31:0]      shreg;
  logic [7:0]       csum;
  logic [IDX_W-1:0] byte_idx;
  logic [ACK_W-1:0] ack_cnt;
  logic [7:0]       next_byte;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      fifo_dout;
  logic             drop;

  // The head is only ever removed in LOAD, and LOAD is entered only when non-empty.
  assign fifo_pop  = (state == LOAD);
  assign fifo_push = nonce_valid && (!fifo_full || fifo_pop);
  assign drop      = nonce_valid && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (nonce),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Status is decoded from flops only; there is no input-to-output path.
  assign nonce_ready = !fifo_full;
  assign busy        = (state != IDLE) || !fifo_empty;

  // Byte mux: the shift register always presents the next nonce byte in [7:0].
  always_comb begin
    next_byte = shreg[7:0];
    if (byte_idx == '0)           next_byte = SYNC_BYTE;
    else if (byte_idx == IDX_LAST) next_byte = csum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != '1)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      csum        <= '0;
      byte_idx    <= '0;
      ack_cnt     <= '0;
      tx_transmit <= 1'b0;
      tx_byte     <= '0;
    end else begin
      tx_transmit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          shreg    <= fifo_dout;
          csum     <= nonce_csum(fifo_dout);
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          // Waiting for idle also lets a byte left over from before a reset finish.
          if (!tx_busy) begin
            tx_transmit <= 1'b1;
            tx_byte     <= next_byte;
            ack_cnt     <= '0;
            state       <= ACK;
          end
        end
        ACK: begin
          // The UART raises busy one cycle after it samples the request.
          if (tx_busy) begin
            state <= DONE;
          end else if (ack_cnt == ACK_LAST) begin
            state <= SEND;  // request was missed: re-issue the same byte
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!tx_busy) begin
            if (byte_idx == IDX_LAST) begin
              state <= IDLE;
            end else begin
              // Index 0 was SYNC, so the first nonce byte is already in place.
              if (byte_idx != '0) shreg <= {8'h00, shreg[31:8]};
              byte_idx <= byte_idx + 1'b1;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_tx_framer.sv
// Self-checking bench for nonce_tx_framer: behavioural UART, byte scoreboard.
// Latency: n/a.
// Backpressure: the UART model can be muted to exercise the request retry path.
module tb_nonce_tx_framer;

  import nonce_tx_framer_pkg::*;

  localparam int         DEPTH    = 4;
  localparam int         OVF_W    = 8;
  localparam int         BYTE_CYC = 12;
  localparam logic [7:0] SYNC_EXP = 8'hAA;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             nonce_valid = 1'b0;
  logic [31:0]      nonce = '0;
  logic             nonce_ready;
  logic             tx_busy;
  logic             tx_transmit;
  logic [7:0]       tx_byte;
  logic             busy;
  logic [OVF_W-1:0] ovf_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q [$];
  logic       uart_busy = 1'b0;
  logic       uart_mute = 1'b0;
  logic       uart_take = 1'b0;
  int         uart_cnt  = 0;
  int         rx_bytes  = 0;
  logic       prev_tx   = 1'b0;

  assign tx_busy = uart_busy;

  always #5 clk = ~clk;

  nonce_tx_framer #(
    .SYNC_BYTE  (8'hAA),
    .FIFO_DEPTH (DEPTH),
    .OVF_W      (OVF_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nonce_valid (nonce_valid),
    .nonce       (nonce),
    .nonce_ready (nonce_ready),
    .tx_busy     (tx_busy),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte),
    .busy        (busy),
    .ovf_count   (ovf_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_bytes(input logic [31:0] n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 4; i++) c = c ^ n[8*i +: 8];
    return c;
  endfunction

  task automatic expect_frame(input logic [31:0] n);
    exp_q.push_back({1'b0, SYNC_EXP});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, n[8*i +: 8]});
    exp_q.push_back({1'b0, xor_bytes(n)});
  endtask

  // Byte monitor and protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    logic [8:0] e;
    uart_take = 1'b0;
    if (tx_transmit) begin
      check_eq("tx_while_busy", 32'(uart_busy), 32'd0);
      check_eq("tx_back_to_back", 32'(prev_tx), 32'd0);
      if (!uart_busy && !uart_mute) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;  // 9'h100 never matches
        check_eq("tx_byte", 32'(tx_byte), 32'(e));
        uart_take = 1'b1;
        rx_bytes++;
      end
    end
    prev_tx = tx_transmit;
  end

  // UART: raises is_transmitting the edge after it samples a request, holds it BYTE_CYC cycles.
  always @(posedge clk) begin
    if (uart_take) begin
      uart_busy <= 1'b1;
      uart_cnt  <= BYTE_CYC;
    end else if (uart_busy) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_busy <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] n);
    nonce       = n;
    nonce_valid = 1'b1;
    step();
    nonce_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || uart_busy || exp_q.size() != 0) && k < 3000) begin
      step();
      k++;
    end
    check_eq({tag, "_busy_clear"}, 32'(busy), 32'd0);
    check_eq({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_tx(output int cycles);
    cycles = 0;
    while (!tx_transmit && cycles < 50) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          base;
    logic [7:0]  b1;
    logic [31:0] t3 [6];

    // Reset state
    step(); step();
    check_eq("rst_tx_transmit", 32'(tx_transmit), 32'd0);
    check_eq("rst_tx_byte", 32'(tx_byte), 32'd0);
    check_eq("rst_ovf", 32'(ovf_count), 32'd0);
    check_eq("rst_ready", 32'(nonce_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: single nonce, literal frame, 3-cycle latency, busy until the UART drains
    exp_q.push_back(9'h0AA); exp_q.push_back(9'h078); exp_q.push_back(9'h056);
    exp_q.push_back(9'h034); exp_q.push_back(9'h012); exp_q.push_back(9'h008);
    push(32'h1234_5678);
    check_eq("t1_busy_after_push", 32'(busy), 32'd1);
    wait_tx(k);
    check_eq("t1_latency", 32'(k), 32'd3);
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin step(); k++; end
    check_eq("t1_busy_last_byte", 32'(busy), 32'd1);
    k = 0;
    while (uart_busy && k < 100) begin step(); k++; end
    step(); step();
    check_eq("t1_busy_fall", 32'(busy), 32'd0);
    wait_idle("t1");

    // 2: three back-to-back nonces come out in order
    expect_frame(32'h0102_0304); expect_frame(32'h0); expect_frame(32'hFFFF_FFFF);
    push(32'h0102_0304); push(32'h0); push(32'hFFFF_FFFF);
    wait_idle("t2");

    // 3: six pushes in six cycles; the first is popped early, the sixth is dropped
    t3 = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004, 32'hE000_0005, 32'hF000_0006};
    for (int i = 0; i < 5; i++) expect_frame(t3[i]);
    for (int i = 0; i < 5; i++) push(t3[i]);
    check_eq("t3_ready_full", 32'(nonce_ready), 32'd0);
    push(t3[5]);
    check_eq("t3_ovf", 32'(ovf_count), 32'd1);
    wait_idle("t3");
    check_eq("t3_ready_after", 32'(nonce_ready), 32'd1);

    // 4: queue full, push lands in the LOAD-pop cycle and is accepted
    expect_frame(32'h4000_000A);
    push(32'h4000_000A);
    step(); step(); step();
    for (int i = 0; i < 4; i++) begin
      expect_frame(32'h4000_0010 + 32'(i));
      push(32'h4000_0010 + 32'(i));
    end
    check_eq("t4_ready_full", 32'(nonce_ready), 32'd0);
    k = 0;
    while (dut.state != LOAD && k < 1000) begin step(); k++; end
    check_eq("t4_found_load", 32'(dut.state == LOAD), 32'd1);
    expect_frame(32'h4000_00FF);
    push(32'h4000_00FF);
    check_eq("t4_ovf_unchanged", 32'(ovf_count), 32'd1);
    check_eq("t4_ready_refull", 32'(nonce_ready), 32'd0);
    wait_idle("t4");

    // 6: UART ignores the request -> same byte re-requested after the ACK window
    uart_mute = 1'b1;
    expect_frame(32'h6666_0001);
    push(32'h6666_0001);
    wait_tx(k);
    b1 = tx_byte;
    check_eq("t6_first_byte", 32'(b1), 32'(SYNC_EXP));
    step();
    wait_tx(k);
    // ACK_TIMEOUT cycles in ACK, then one SEND cycle before the next request.
    check_eq("t6_retry_gap", 32'(k + 1), 32'd5);
    check_eq("t6_retry_byte", 32'(tx_byte), 32'(b1));
    uart_mute = 1'b0;
    wait_idle("t6");

    // 7: long burst with the UART stalled saturates the overflow counter
    uart_mute = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i < 5) expect_frame(32'h7700_0000 + 32'(i));
      push(32'h7700_0000 + 32'(i));
    end
    check_eq("t7_ovf_sat", 32'(ovf_count), 32'hFF);
    check_eq("t7_ready_full", 32'(nonce_ready), 32'd0);
    uart_mute = 1'b0;
    wait_idle("t7");

    // 5: reset while byte 2 is on the wire abandons the frame and flushes the queue
    base = rx_bytes;
    expect_frame(32'h5555_0001);
    push(32'h5555_0001);
    step(); step(); step();
    push(32'h5555_0002);
    k = 0;
    while (rx_bytes < base + 3 && k < 1000) begin step(); k++; end
    check_eq("t5_reached_idx2", 32'(rx_bytes - base), 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_tx_transmit", 32'(tx_transmit), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_ready", 32'(nonce_ready), 32'd1);
    check_eq("t5_rst_ovf", 32'(ovf_count), 32'd0);
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    check_eq("t5_uart_still_busy", 32'(uart_busy), 32'd1);
    expect_frame(32'h5555_0003);
    push(32'h5555_0003);
    wait_idle("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
